// File: rtl/enemy_fire_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : enemy_fire_ctrl_if
// Description : Bundle between the enemy fire controller and the game logic:
//               alive flags, bullet status, launch handshake and shooter IDs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface enemy_fire_ctrl_if #(
    parameter int NUM_ENEMIES = 40
);
    logic                   enable;
    logic [NUM_ENEMIES-1:0] vivo_inimigo;
    logic                   shot_busy;
    logic                   fire_ack;
    logic                   fire_req;
    logic [9:0]             ID_enemy_tiro_X;
    logic [9:0]             ID_enemy_tiro_Y;
    logic                   no_target;
    logic [7:0]             shots_fired;

    // Controller side: issues launch requests
    modport master (
        input  enable, vivo_inimigo, shot_busy, fire_ack,
        output fire_req, ID_enemy_tiro_X, ID_enemy_tiro_Y, no_target, shots_fired
    );

    // Game/launcher side
    modport slave (
        output enable, vivo_inimigo, shot_busy, fire_ack,
        input  fire_req, ID_enemy_tiro_X, ID_enemy_tiro_Y, no_target, shots_fired
    );
endinterface

`default_nettype wire

// File: rtl/enemy_fire_ctrl.sv
//------------------------------------------------------------------------------
// Module      : enemy_fire_ctrl
// Description : Picks a random column after each cooldown, scans it bottom-up
//               for a live enemy (moving to the next column on a miss) and
//               requests a bullet launch from that enemy.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module enemy_fire_ctrl #(
    parameter int          LINHAS   = 4,               // rows, 1..8
    parameter int          COLUNAS  = 10,              // columns, 2..16
    parameter logic [23:0] COOLDOWN = 24'd12_500_000,  // cycles between shots
    parameter logic [15:0] SEED     = 16'hACE1         // LFSR reset value, nonzero
) (
    input  wire logic         clk,
    input  wire logic         reset,
    enemy_fire_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CD   = 3'd1,
        ST_PICK = 3'd2,
        ST_SCAN = 3'd3,
        ST_FIRE = 3'd4
    } state_t;

    localparam logic [6:0]  C_COLS7    = 7'(COLUNAS);
    localparam logic [4:0]  C_NUM_COLS = 5'(COLUNAS);
    localparam logic [3:0]  C_LAST_COL = 4'(COLUNAS - 1);
    localparam logic [2:0]  C_LAST_ROW = 3'(LINHAS - 1);
    localparam logic [23:0] C_CD_LOAD  = COOLDOWN - 24'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic [3:0]  r_col;
    logic [3:0]  w_col_nxt;
    logic [2:0]  r_row;
    logic [2:0]  w_row_nxt;
    logic [4:0]  r_tried;
    logic [4:0]  w_tried_nxt;
    logic [9:0]  r_id_x;
    logic [9:0]  w_id_x_nxt;
    logic [9:0]  r_id_y;
    logic [9:0]  w_id_y_nxt;
    logic [7:0]  r_shots;
    logic [7:0]  w_shots_nxt;
    logic        r_no_target;
    logic        w_no_target_nxt;

    logic [127:0] w_vivo_pad;
    logic [6:0]   w_scan_idx;
    logic         w_scan_hit;
    logic         w_tgt_alive;
    logic [3:0]   w_pick_col;

    // Alive flags widened so any 7-bit flat index selects a defined bit
    assign w_vivo_pad  = 128'(bus.vivo_inimigo);
    assign w_scan_idx  = (7'(r_row) * C_COLS7) + 7'(r_col);
    assign w_scan_hit  = w_vivo_pad[w_scan_idx];
    assign w_tgt_alive = w_vivo_pad[r_id_x[6:0]];

    // Random column from the LFSR low nibble; for COLUNAS >= 8 this is exactly
    // one conditional subtraction of COLUNAS, smaller grids still land in range
    assign w_pick_col = 4'(({1'b0, r_lfsr[3:0]}) % C_NUM_COLS);

    // Fibonacci feedback for taps 16/14/13/11
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR, shifts every cycle regardless of state or enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath updates; dropping enable overrides everything
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_tried_nxt     = r_tried;
        w_id_x_nxt      = r_id_x;
        w_id_y_nxt      = r_id_y;
        w_shots_nxt     = r_shots;
        w_no_target_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = ST_CD;
                    w_cnt_nxt   = C_CD_LOAD;
                end
            end

            ST_CD: begin
                if (r_cnt != 24'd0) begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end else if (!bus.shot_busy) begin
                    w_state_nxt = ST_PICK;
                end
            end

            ST_PICK: begin
                w_col_nxt   = w_pick_col;
                w_row_nxt   = C_LAST_ROW;
                w_tried_nxt = 5'd0;
                w_state_nxt = ST_SCAN;
            end

            ST_SCAN: begin
                if (w_scan_hit) begin
                    w_id_x_nxt  = {3'b000, w_scan_idx};
                    w_id_y_nxt  = {7'b0000000, r_row};
                    w_state_nxt = ST_FIRE;
                end else if (r_row != 3'd0) begin
                    w_row_nxt = r_row - 3'd1;
                end else begin
                    // Column exhausted: move right (wrapping) and restart at the bottom
                    w_col_nxt   = (r_col == C_LAST_COL) ? 4'd0 : r_col + 4'd1;
                    w_row_nxt   = C_LAST_ROW;
                    w_tried_nxt = r_tried + 5'd1;
                    if ((r_tried + 5'd1) == C_NUM_COLS) begin
                        w_no_target_nxt = 1'b1;
                        w_state_nxt     = ST_CD;
                        w_cnt_nxt       = C_CD_LOAD;
                    end
                end
            end

            ST_FIRE: begin
                // Ack wins over a simultaneous target death
                if (bus.fire_ack) begin
                    w_shots_nxt = r_shots + 8'd1;
                    w_state_nxt = ST_CD;
                    w_cnt_nxt   = C_CD_LOAD;
                end else if (!w_tgt_alive) begin
                    w_state_nxt = ST_PICK;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (!bus.enable) begin
            w_state_nxt     = ST_IDLE;
            w_id_x_nxt      = r_id_x;
            w_id_y_nxt      = r_id_y;
            w_shots_nxt     = r_shots;
            w_no_target_nxt = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 24'd0;
            r_col       <= 4'd0;
            r_row       <= 3'd0;
            r_tried     <= 5'd0;
            r_id_x      <= 10'd0;
            r_id_y      <= 10'd0;
            r_shots     <= 8'd0;
            r_no_target <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_tried     <= w_tried_nxt;
            r_id_x      <= w_id_x_nxt;
            r_id_y      <= w_id_y_nxt;
            r_shots     <= w_shots_nxt;
            r_no_target <= w_no_target_nxt;
        end
    end

    // Request is a pure function of the registered state, so reset clears it at once
    assign bus.fire_req        = (r_state == ST_FIRE);
    assign bus.ID_enemy_tiro_X = r_id_x;
    assign bus.ID_enemy_tiro_Y = r_id_y;
    assign bus.no_target       = r_no_target;
    assign bus.shots_fired     = r_shots;

endmodule

`default_nettype wire

// File: tb/tb_enemy_fire_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_enemy_fire_ctrl
// Description : Directed self-checking bench for enemy_fire_ctrl
//               (4 rows x 10 columns, cooldown of 8 cycles).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_enemy_fire_ctrl;

    localparam int N = 40;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic         en      = 1'b0;
    logic [N-1:0] vivo    = '1;
    logic         busy    = 1'b0;
    logic         ack_man = 1'b0;
    logic         tie_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    enemy_fire_ctrl_if #(.NUM_ENEMIES(N)) ifc ();

    assign ifc.enable       = en;
    assign ifc.vivo_inimigo = vivo;
    assign ifc.shot_busy    = busy;
    assign ifc.fire_ack     = tie_ack ? ifc.fire_req : ack_man;

    enemy_fire_ctrl #(
        .LINHAS   (4),
        .COLUNAS  (10),
        .COOLDOWN (24'd8),
        .SEED     (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges until fire_req is seen high, bounded by limit
    task automatic wait_rise(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ifc.fire_req !== 1'b1 && n < limit);
    endtask

    initial begin
        int n;
        int kx;
        int saved_x;
        int pulses;
        int highs;

        // Reset state
        repeat (3) tick();
        check("rst_fire_req",  32'(ifc.fire_req), 0);
        check("rst_no_target", 32'(ifc.no_target), 0);
        check("rst_id_x",      32'(ifc.ID_enemy_tiro_X), 0);
        check("rst_id_y",      32'(ifc.ID_enemy_tiro_Y), 0);
        check("rst_shots",     32'(ifc.shots_fired), 0);

        // All alive, ack tied to request: full cooldown first, then 11-cycle spacing
        reset   = 1'b0;
        en      = 1'b1;
        tie_ack = 1'b1;
        wait_rise(30, n);
        check("first_latency", 32'(n), 11);
        check("first_x_seed",  32'(ifc.ID_enemy_tiro_X), 38);
        check("first_y",       32'(ifc.ID_enemy_tiro_Y), 3);
        for (int k = 1; k <= 4; k++) begin
            wait_rise(30, n);
            check("spacing",  32'(n), 11);
            check("y_bottom", 32'(ifc.ID_enemy_tiro_Y), 3);
            check("x_range",  32'(ifc.ID_enemy_tiro_X >= 10'd30 && ifc.ID_enemy_tiro_X <= 10'd39), 1);
            check("shots_k",  32'(ifc.shots_fired), 32'(k));
        end
        tick();
        tie_ack = 1'b0;
        check("shots_5", 32'(ifc.shots_fired), 5);

        // Only enemy 5 alive (row 0, col 5)
        vivo = 40'h00_0000_0020;
        wait_rise(200, n);
        check("lone_x", 32'(ifc.ID_enemy_tiro_X), 5);
        check("lone_y", 32'(ifc.ID_enemy_tiro_Y), 0);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("lone_shots1", 32'(ifc.shots_fired), 6);
        check("lone_req_low", 32'(ifc.fire_req), 0);
        wait_rise(200, n);
        check("lone_x2", 32'(ifc.ID_enemy_tiro_X), 5);
        check("lone_y2", 32'(ifc.ID_enemy_tiro_Y), 0);
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        check("lone_shots2", 32'(ifc.shots_fired), 7);

        // Nobody alive for 200 cycles: a search every 49 cycles, pulses after 49/98/147/196
        vivo   = '0;
        pulses = 0;
        highs  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ifc.no_target === 1'b1) pulses++;
            if (ifc.fire_req === 1'b1) highs++;
        end
        check("empty_no_target", 32'(pulses), 4);
        check("empty_fire_req",  32'(highs), 0);

        // shot_busy holds the controller after cooldown
        vivo  = '1;
        busy  = 1'b1;
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ifc.fire_req === 1'b1) highs++;
        end
        check("busy_hold", 32'(highs), 0);
        busy = 1'b0;
        wait_rise(10, n);
        check("busy_release_lat", 32'(n), 3);
        check("busy_y",           32'(ifc.ID_enemy_tiro_Y), 3);

        // Drop enable while requesting: IDLE, IDs and count kept, then full cooldown
        saved_x = 32'(ifc.ID_enemy_tiro_X);
        en = 1'b0;
        tick();
        check("dis_req_low", 32'(ifc.fire_req), 0);
        check("dis_x_kept",  32'(ifc.ID_enemy_tiro_X), 32'(saved_x));
        check("dis_shots",   32'(ifc.shots_fired), 7);
        repeat (2) tick();
        en = 1'b1;
        wait_rise(30, n);
        check("reenable_lat", 32'(n), 11);

        // Kill the target while requesting: drop and re-pick without cooldown
        kx = 32'(ifc.ID_enemy_tiro_X);
        vivo[kx] = 1'b0;
        tick();
        check("kill_req_low", 32'(ifc.fire_req), 0);
        wait_rise(10, n);
        check("kill_repick_fast", 32'(n == 2 || n == 3), 1);
        check("kill_new_target",  32'(32'(ifc.ID_enemy_tiro_X) != kx), 1);
        check("kill_req_high",    32'(ifc.fire_req), 1);

        // Ack and death in the same cycle still count
        vivo[ifc.ID_enemy_tiro_X] = 1'b0;
        ack_man = 1'b1;
        tick();
        check("ack_death_shots", 32'(ifc.shots_fired), 8);
        check("ack_death_req",   32'(ifc.fire_req), 0);

        // Ack outside FIRE is ignored
        repeat (3) tick();
        ack_man = 1'b0;
        check("stray_ack", 32'(ifc.shots_fired), 8);

        // Asynchronous reset mid-cooldown, observed between edges
        vivo = '1;
        tick();
        reset = 1'b1;
        #1;
        check("arst_shots",     32'(ifc.shots_fired), 0);
        check("arst_id_x",      32'(ifc.ID_enemy_tiro_X), 0);
        check("arst_id_y",      32'(ifc.ID_enemy_tiro_Y), 0);
        check("arst_fire_req",  32'(ifc.fire_req), 0);
        check("arst_no_target", 32'(ifc.no_target), 0);
        repeat (2) tick();
        reset = 1'b0;
        wait_rise(30, n);
        check("arst_latency", 32'(n), 11);
        check("arst_seed_x",  32'(ifc.ID_enemy_tiro_X), 38);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
